// File: rtl/incdec_seq_pkg.sv
// Shared types and defaults for the inc/dec command sequencer.
// Imported by incdec_cmd_fifo and incdec_cmd_sequencer.
package incdec_seq_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } seq_state_e;

    typedef struct packed {
        logic                 dir;
        logic [DEF_WIDTH-1:0] val;
    } cmd_t;

endpackage

// File: rtl/incdec_cmd_fifo.sv
// Registered command FIFO, pointers carry an extra wrap bit.
// Head entry is presented combinationally on dout.
module incdec_cmd_fifo
    import incdec_seq_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    parameter type T     = cmd_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T           mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; occupancy lives in the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/incdec_cmd_sequencer.sv
// Feeds queued {dir,value} commands to an external inc/dec stage.
// Optional sticky wrap detection: INCDEC_SEQ_WRAP_CHECK_EN.
module incdec_cmd_sequencer
    import incdec_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_dir_i,
    input  logic [WIDTH-1:0] cmd_val_i,
    output logic             stage_cond_o,
    output logic [WIDTH-1:0] stage_val_o,
    input  logic [WIDTH-1:0] stage_res_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_val_o,
    output logic             rsp_dir_o,
    output logic [CNT_W-1:0] inc_count_o,
    output logic [CNT_W-1:0] dec_count_o,
    output logic             busy_o,
    output logic             wrap_o
);

    typedef struct packed {
        logic             dir;
        logic [WIDTH-1:0] val;
    } cmd_w_t;

    seq_state_e state_q;
    seq_state_e state_d;
    cmd_w_t     push_cmd;
    cmd_w_t     head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       rsp_hs;

    assign push_cmd    = '{dir: cmd_dir_i, val: cmd_val_i};
    assign cmd_ready_o = !fifo_full;
    assign push        = cmd_valid_i && !fifo_full;
    assign rsp_hs      = rsp_valid_o && rsp_ready_i;

    incdec_cmd_fifo #(
        .DEPTH (DEPTH),
        .T     (cmd_w_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_cmd),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!fifo_empty) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (rsp_hs) state_d = fifo_empty ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        busy_o = (state_q != IDLE) || !fifo_empty;
        unique case (state_q)
            IDLE:    pop = !fifo_empty;
            RESP:    pop = rsp_hs && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    // Stage inputs persist until the next pop; ISSUE samples the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_cond_o <= 1'b0;
            stage_val_o  <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_val_o    <= '0;
            rsp_dir_o    <= 1'b0;
        end else begin
            if (pop) begin
                stage_cond_o <= head.dir;
                stage_val_o  <= head.val;
            end
            if (state_q == ISSUE) begin
                rsp_val_o   <= stage_res_i;
                rsp_dir_o   <= stage_cond_o;
                rsp_valid_o <= 1'b1;
            end else if (rsp_hs) begin
                rsp_valid_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_count_o <= '0;
            dec_count_o <= '0;
        end else if (rsp_hs) begin
            if (rsp_dir_o) begin
                if (inc_count_o != '1)
                    inc_count_o <= inc_count_o + CNT_W'(1);
            end else begin
                if (dec_count_o != '1)
                    dec_count_o <= dec_count_o + CNT_W'(1);
            end
        end
    end

`ifdef INCDEC_SEQ_WRAP_CHECK_EN
    logic             wrap_q;
    logic             wrap_hit;
    logic [WIDTH-1:0] exp_res;

    assign wrap_hit = stage_cond_o ? (&stage_val_o) : ~|stage_val_o;
    assign exp_res  = stage_cond_o ? stage_val_o + WIDTH'(1)
                                   : stage_val_o - WIDTH'(1);
    assign wrap_o   = wrap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         wrap_q <= 1'b0;
        else if (state_q == ISSUE && wrap_hit) wrap_q <= 1'b1;
    end

    always @(posedge clk) begin
        if (rst_n && state_q == ISSUE)
            assert (stage_res_i == exp_res);
    end
`else
    assign wrap_o = 1'b0;
`endif

endmodule
